// File: rtl/fifo_rr_arbiter.sv
// Packet-granular round-robin arbiter: drains NUM_QUEUES fallthrough FIFOs onto one
// registered output stream, holding the grant from the first word to the EOP word.
module fifo_rr_arbiter #(
    parameter int unsigned WIDTH      = 72,
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned QSEL_BITS  = 2,
    parameter int unsigned EOP_BIT    = WIDTH - 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_QUEUES*WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES-1:0]         in_empty,
    output logic [NUM_QUEUES-1:0]         in_rd_en,
    input  logic [NUM_QUEUES-1:0]         queue_enable,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_wr,
    input  logic                          out_rdy,
    output logic [QSEL_BITS-1:0]          grant,
    output logic                          busy,
    output logic                          pkt_done
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [QSEL_BITS-1:0]  r_last_grant;
    logic [QSEL_BITS-1:0]  r_grant;
    logic [QSEL_BITS-1:0]  w_pick;
    logic                  w_found;
    logic [NUM_QUEUES-1:0] w_elig;
    logic [WIDTH-1:0]      w_head;
    logic                  w_head_empty;
    logic                  w_rd;
    logic                  w_eop;
    logic [WIDTH-1:0]      r_out_data;
    logic                  r_out_wr;
    logic                  r_pkt_done;

    assign w_elig = ~in_empty & queue_enable;
    assign w_eop  = w_head[EOP_BIT];

    // Select the head word and empty flag of the granted queue.
    always_comb begin
        w_head       = '0;
        w_head_empty = 1'b1;
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            if (r_grant == QSEL_BITS'(i)) begin
                w_head       = in_data[i*WIDTH +: WIDTH];
                w_head_empty = in_empty[i];
            end
        end
    end

    // Rotating priority search: starts just after the last grant, last grant checked last.
    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = 0;
        for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
            v_idx = (32'(r_last_grant) + k) % NUM_QUEUES;
            for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
                if (!w_found && (i == v_idx) && w_elig[i]) begin
                    w_found = 1'b1;
                    w_pick  = QSEL_BITS'(i);
                end
            end
        end
    end

    // Next state and read strobe; only the granted queue is ever read, only while streaming.
    always_comb begin
        w_state_d = r_state;
        in_rd_en  = '0;
        w_rd      = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_d = StStream;
                end
            end
            StStream: begin
                w_rd = out_rdy & ~w_head_empty;
                for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
                    if (r_grant == QSEL_BITS'(i)) begin
                        in_rd_en[i] = w_rd;
                    end
                end
                if (w_rd && w_eop) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_last_grant <= QSEL_BITS'(NUM_QUEUES - 1);
            r_grant      <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && w_found) begin
                r_grant <= w_pick;
            end
            if (w_rd && w_eop) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Registered output word stream; data holds when nothing is read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data <= '0;
            r_out_wr   <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_out_wr   <= w_rd;
            r_pkt_done <= w_rd & w_eop;
            if (w_rd) begin
                r_out_data <= w_head;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_wr   = r_out_wr;
    assign grant    = r_grant;
    assign busy     = (r_state == StStream);
    assign pkt_done = r_pkt_done;

endmodule
